ysyx_lsu_resp: RTL

Load/store responder for the execute stage's memory request interface. Accepts one load or store from the reservation station's LSU port and performs it as a single AXI4-Lite-style transaction on the data bus. Stores use byte-lane alignment and write strobes. Loads are returned with byte-lane extraction and sign/zero extension, then signalled back with a one-cycle valid pulse.

---
 rtl/ysyx_pkg.sv | 32 +++
 rtl/ysyx_lsu_lane.sv | 41 ++++
 rtl/ysyx_lsu_resp.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/ysyx_pkg.sv
// Shared LSU definitions: FSM states, funct3 access sizes, AXI response codes
// and the alignment helper used by the optional misalignment check.
package ysyx_pkg;

  typedef enum logic [2:0] {
    LSU_IDLE,
    LSU_RD_A,
    LSU_RD_D,
    LSU_WR_AW,
    LSU_WR_B,
    LSU_RESP
  } lsu_state_e;

  localparam logic [2:0] LSU_B  = 3'b000;
  localparam logic [2:0] LSU_H  = 3'b001;
  localparam logic [2:0] LSU_W  = 3'b010;
  localparam logic [2:0] LSU_BU = 3'b100;
  localparam logic [2:0] LSU_HU = 3'b101;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  // funct3[1:0] encodes the access size for both signed and unsigned loads.
  function automatic logic lsu_misaligned(input logic [2:0] funct3, input logic [1:0] off);
    case (funct3[1:0])
      2'b01:   return off[0];
      2'b10:   return (off != 2'b00);
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/ysyx_lsu_lane.sv
// Byte-lane steering: store data/strobe alignment and load extract/extend.
// Purely combinational; bytes shifted past lane 3 are dropped.
module ysyx_lsu_lane
  import ysyx_pkg::*;
#(
  parameter int W = 32
) (
  input  logic [1:0]     off,
  input  logic [2:0]     funct3,
  input  logic [W-1:0]   st_data,
  input  logic [W-1:0]   ld_raw,
  output logic [W-1:0]   st_wdata,
  output logic [W/8-1:0] st_wstrb,
  output logic [W-1:0]   ld_data
);

  logic [W/8-1:0] base;
  logic [W-1:0]   lane;

  always_comb begin
    base = '1;
    case (funct3[1:0])
      2'b00:   base = (W/8)'(1);
      2'b01:   base = (W/8)'(3);
      default: base = '1;
    endcase
    st_wdata = st_data << {off, 3'b000};
    st_wstrb = base << off;

    lane    = ld_raw >> {off, 3'b000};
    ld_data = lane;
    case (funct3)
      LSU_B:   ld_data = {{(W-8){lane[7]}}, lane[7:0]};
      LSU_H:   ld_data = {{(W-16){lane[15]}}, lane[15:0]};
      LSU_BU:  ld_data = {{(W-8){1'b0}}, lane[7:0]};
      LSU_HU:  ld_data = {{(W-16){1'b0}}, lane[15:0]};
      default: ld_data = lane;
    endcase
  end

endmodule

// File: rtl/ysyx_lsu_resp.sv
// LSU responder: one load/store per request as a single AXI4-Lite transaction.
// Optional YSYX_LSU_MISALIGN_CHECK_EN faults misaligned H/W accesses without bus traffic.
`ifndef YSYX_XLEN
`define YSYX_XLEN 32
`endif

module ysyx_lsu_resp
  import ysyx_pkg::*;
#(
  parameter int XLEN  = `YSYX_XLEN,
  parameter int BUS_W = 32
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               flush_pipeline,
  input  logic               in_avalid,
  input  logic               in_ren,
  input  logic               in_wen,
  input  logic [XLEN-1:0]    in_addr,
  input  logic [4:0]         in_alu_op,
  input  logic [XLEN-1:0]    in_wdata,
  output logic [XLEN-1:0]    out_rdata,
  output logic               out_rvalid,
  output logic               out_wready,
  output logic               out_fault,
  output logic               out_busy,
  output logic [XLEN-1:0]    bus_araddr,
  output logic               bus_arvalid,
  input  logic               bus_arready,
  input  logic [BUS_W-1:0]   bus_rdata,
  input  logic [1:0]         bus_rresp,
  input  logic               bus_rvalid,
  output logic               bus_rready,
  output logic [XLEN-1:0]    bus_awaddr,
  output logic               bus_awvalid,
  input  logic               bus_awready,
  output logic [BUS_W-1:0]   bus_wdata,
  output logic [BUS_W/8-1:0] bus_wstrb,
  output logic               bus_wvalid,
  input  logic               bus_wready,
  input  logic [1:0]         bus_bresp,
  input  logic               bus_bvalid,
  output logic               bus_bready
);

  lsu_state_e      state_q, state_d;
  logic            armed_q, armed_d;
  logic            is_load_q, is_load_d;
  logic            flushed_q, flushed_d;
  logic [1:0]      resp_q, resp_d;
  logic [XLEN-1:0] rdata_q, rdata_d;
  logic [XLEN-1:0] addr_q, addr_d;
  logic [XLEN-1:0] wdata_q, wdata_d;
  logic [2:0]      op_q, op_d;
  logic            arvalid_q, arvalid_d, rready_q, rready_d;
  logic            awvalid_q, awvalid_d, wvalid_q, wvalid_d, bready_q, bready_d;
  logic            misalign;
  logic            aw_pending, w_pending;
  logic [XLEN-1:0] lane_rdata;
  logic            unused_ok;

  assign unused_ok = &{1'b0, in_alu_op[4:3]};

`ifdef YSYX_LSU_MISALIGN_CHECK_EN
  assign misalign = lsu_misaligned(in_alu_op[2:0], in_addr[1:0]);
`else
  assign misalign = 1'b0;
`endif

  ysyx_lsu_lane #(.W(XLEN)) u_lane (
    .off      (addr_q[1:0]),
    .funct3   (op_q),
    .st_data  (wdata_q),
    .ld_raw   (bus_rdata),
    .st_wdata (bus_wdata),
    .st_wstrb (bus_wstrb),
    .ld_data  (lane_rdata)
  );

  always_comb begin
    state_d   = state_q;
    armed_d   = armed_q;
    is_load_d = is_load_q;
    flushed_d = flushed_q;
    resp_d    = resp_q;
    rdata_d   = rdata_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    op_d      = op_q;
    arvalid_d = arvalid_q;
    rready_d  = rready_q;
    awvalid_d = awvalid_q;
    wvalid_d  = wvalid_q;
    bready_d  = bready_q;
    aw_pending = awvalid_q && !bus_awready;
    w_pending  = wvalid_q && !bus_wready;

    // A dropped request re-arms acceptance so a held request is never re-issued.
    if (!in_avalid) armed_d = 1'b1;
    if (flush_pipeline && (state_q != LSU_IDLE) && (state_q != LSU_RESP)) flushed_d = 1'b1;

    case (state_q)
      LSU_IDLE: begin
        if (in_avalid && armed_q && (in_ren || in_wen)) begin
          addr_d    = in_addr;
          op_d      = in_alu_op[2:0];
          wdata_d   = in_wdata;
          is_load_d = in_ren;
          flushed_d = 1'b0;
          resp_d    = RESP_OKAY;
          if (misalign) begin
            state_d = LSU_RESP;
            resp_d  = RESP_SLVERR;
            rdata_d = '0;
          end else if (in_ren) begin
            state_d   = LSU_RD_A;
            arvalid_d = 1'b1;
          end else begin
            state_d   = LSU_WR_AW;
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
          end
        end
      end
      LSU_RD_A: begin
        if (bus_arready) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          state_d   = LSU_RD_D;
        end
      end
      LSU_RD_D: begin
        if (bus_rvalid) begin
          rready_d = 1'b0;
          rdata_d  = lane_rdata;
          resp_d   = bus_rresp;
          state_d  = LSU_RESP;
        end
      end
      LSU_WR_AW: begin
        awvalid_d = aw_pending;
        wvalid_d  = w_pending;
        if (!aw_pending && !w_pending) begin
          bready_d = 1'b1;
          state_d  = LSU_WR_B;
        end
      end
      LSU_WR_B: begin
        if (bus_bvalid) begin
          bready_d = 1'b0;
          resp_d   = bus_bresp;
          state_d  = LSU_RESP;
        end
      end
      LSU_RESP: begin
        state_d = LSU_IDLE;
        armed_d = flushed_q || !in_avalid;
      end
      default: state_d = LSU_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q   <= LSU_IDLE;
      armed_q   <= 1'b1;
      is_load_q <= 1'b0;
      flushed_q <= 1'b0;
      resp_q    <= RESP_OKAY;
      rdata_q   <= '0;
      arvalid_q <= 1'b0;
      rready_q  <= 1'b0;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      bready_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      armed_q   <= armed_d;
      is_load_q <= is_load_d;
      flushed_q <= flushed_d;
      resp_q    <= resp_d;
      rdata_q   <= rdata_d;
      arvalid_q <= arvalid_d;
      rready_q  <= rready_d;
      awvalid_q <= awvalid_d;
      wvalid_q  <= wvalid_d;
      bready_q  <= bready_d;
    end
  end

  always_ff @(posedge clock) begin
    addr_q  <= addr_d;
    wdata_q <= wdata_d;
    op_q    <= op_d;
  end

  assign bus_araddr  = {addr_q[XLEN-1:2], 2'b00};
  assign bus_awaddr  = {addr_q[XLEN-1:2], 2'b00};
  assign bus_arvalid = arvalid_q;
  assign bus_rready  = rready_q;
  assign bus_awvalid = awvalid_q;
  assign bus_wvalid  = wvalid_q;
  assign bus_bready  = bready_q;

  // A flushed load completes silently; stores always report.
  assign out_busy   = (state_q != LSU_IDLE);
  assign out_rvalid = (state_q == LSU_RESP) && is_load_q && !flushed_q;
  assign out_wready = (state_q == LSU_RESP) && !is_load_q;
  assign out_fault  = (out_rvalid || out_wready) && (resp_q != RESP_OKAY);
  assign out_rdata  = rdata_q;

endmodule
